// File: rtl/tenbit_ser_to_par.sv
// TMDS lane deserializer: shifts in one bit per edge, aligns on control
// tokens and emits 10-bit characters with a one-cycle valid strobe.
module tenbit_ser_to_par #(
    parameter int LOCK_COUNT = 4,
    parameter int MISS_LIMIT = 3
) (
    input  logic       serial_clock,
    input  logic       reset_n,
    input  logic       serial,
    output logic [9:0] parallel,
    output logic       parallel_valid,
    output logic       locked
);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
    localparam logic [3:0] MISS_N = 4'(MISS_LIMIT);

    state_t state, state_nxt;

    // Bit 0 of the shift register never feeds the window, so it is not kept.
    logic [9:1] sr;
    logic [9:0] w;
    logic [3:0] ph, ph_nxt;
    logic [3:0] good, good_nxt;
    logic [3:0] miss, miss_nxt;
    logic [9:0] par_nxt;
    logic       vld_nxt;
    logic       tok;
    logic       boundary;

    assign w        = {serial, sr[9:1]};
    assign boundary = (ph == 4'd9);
    assign locked   = (state == LOCKED);

    assign tok = (w == 10'b1101010100) || (w == 10'b0010101011) ||
                 (w == 10'b0101010100) || (w == 10'b1010101011);

    always_comb begin
        state_nxt = state;
        ph_nxt    = boundary ? 4'd0 : ph + 4'd1;
        good_nxt  = good;
        miss_nxt  = miss;
        par_nxt   = parallel;
        vld_nxt   = 1'b0;
        unique case (state)
            HUNT: begin
                if (tok) begin
                    ph_nxt   = 4'd0;
                    good_nxt = 4'd1;
                    if (LOCK_COUNT == 1) begin
                        state_nxt = LOCKED;
                        par_nxt   = w;
                        vld_nxt   = 1'b1;
                    end else begin
                        state_nxt = CONFIRM;
                    end
                end
            end
            CONFIRM: begin
                if (boundary) begin
                    if (tok) begin
                        good_nxt = good + 4'd1;
                        if (good + 4'd1 == LOCK_N) begin
                            state_nxt = LOCKED;
                            par_nxt   = w;
                            vld_nxt   = 1'b1;
                        end
                    end else begin
                        state_nxt = HUNT;
                        good_nxt  = 4'd0;
                    end
                end
            end
            LOCKED: begin
                if (boundary) begin
                    par_nxt = w;
                    vld_nxt = 1'b1;
                    if (tok) miss_nxt = 4'd0;
                end else if (tok) begin
                    // Repeated misaligned tokens mean the lane slipped.
                    if (miss + 4'd1 == MISS_N) begin
                        state_nxt = HUNT;
                        miss_nxt  = 4'd0;
                        good_nxt  = 4'd0;
                    end else begin
                        miss_nxt = miss + 4'd1;
                    end
                end
            end
            default: state_nxt = HUNT;
        endcase
    end

    always_ff @(posedge serial_clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= HUNT;
            sr             <= '0;
            ph             <= '0;
            good           <= '0;
            miss           <= '0;
            parallel       <= '0;
            parallel_valid <= 1'b0;
        end else begin
            state          <= state_nxt;
            sr             <= w[9:1];
            ph             <= ph_nxt;
            good           <= good_nxt;
            miss           <= miss_nxt;
            parallel       <= par_nxt;
            parallel_valid <= vld_nxt;
        end
    end

endmodule

// File: tb/tb_tenbit_ser_to_par.sv
// Directed bench for tenbit_ser_to_par: reset, lock, data,
// confirm failure, slip recovery and mid-word reset.
module tb_tenbit_ser_to_par;

    localparam logic [9:0] TOK = 10'b1101010100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ser = 1'b0;
    logic [9:0] parallel;
    logic       parallel_valid;
    logic       locked;

    int n_chk = 0;
    int n_fail = 0;

    int         mid_vld;
    logic [9:0] mid_par;
    logic       end_vld;
    logic [9:0] end_par;
    logic       end_lock;
    int         bad;

    always #5 clk = ~clk;

    tenbit_ser_to_par #(
        .LOCK_COUNT(4),
        .MISS_LIMIT(3)
    ) dut (
        .serial_clock  (clk),
        .reset_n       (rst_n),
        .serial        (ser),
        .parallel      (parallel),
        .parallel_valid(parallel_valid),
        .locked        (locked)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input logic b);
        ser = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [9:0] v);
        mid_vld = 0;
        for (int i = 0; i < 10; i++) begin
            tick(v[i]);
            if (i < 9 && parallel_valid) mid_vld++;
            if (i == 4) mid_par = parallel;
        end
        end_vld  = parallel_valid;
        end_par  = parallel;
        end_lock = locked;
    endtask

    initial begin
        // Reset held with serial toggling
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick(i[0]);
            if (parallel != 10'h0 || parallel_valid || locked) bad++;
        end
        check("rst_hold", bad, 0);
        rst_n = 1'b1;

        // Lock from junk then tokens
        tick(1'b1);
        tick(1'b1);
        tick(1'b1);
        for (int t = 1; t <= 6; t++) begin
            send_word(TOK);
            if (t == 3) check("lock_pre", end_lock, 0);
            if (t == 3) check("no_vld_pre", end_vld, 0);
            if (t == 4) check("lock_rise", end_lock, 1);
            if (t == 4) check("first_vld", end_vld, 1);
            if (t == 4) check("first_par", end_par, 10'h354);
            if (t == 5) check("period_mid", mid_vld, 0);
            if (t == 5) check("period_end", end_vld, 1);
        end

        // Data pass-through
        send_word(10'b1111100000);
        check("d0_vld", end_vld, 1);
        check("d0_par", end_par, 10'h3E0);
        send_word(10'b0000011111);
        check("d1_hold", mid_par, 10'h3E0);
        check("d1_par", end_par, 10'h01F);
        send_word(10'b1010101010);
        check("d2_par", end_par, 10'h2AA);
        check("d2_lock", end_lock, 1);

        // Confirm failure from a fresh hunt
        rst_n = 1'b0;
        tick(1'b0);
        tick(1'b0);
        rst_n = 1'b1;
        bad = 0;
        send_word(TOK);
        bad += mid_vld + int'(end_vld);
        send_word(TOK);
        bad += mid_vld + int'(end_vld);
        send_word(10'b0000000000);
        bad += mid_vld + int'(end_vld);
        check("cf_no_vld", bad, 0);
        check("cf_unlock", end_lock, 0);
        for (int t = 1; t <= 4; t++) begin
            send_word(TOK);
            if (t == 3) check("cf_relock_pre", end_lock, 0);
            if (t == 4) check("cf_relock", end_lock, 1);
            if (t == 4) check("cf_relock_par", end_par, 10'h354);
        end

        // One-bit slip, then tokens at the new phase
        tick(1'b0);
        for (int t = 1; t <= 8; t++) begin
            send_word(TOK);
            if (t == 2) check("slip_hold", end_lock, 1);
            if (t == 3) check("slip_drop", end_lock, 0);
            if (t == 6) check("slip_pre", end_lock, 0);
            if (t == 7) check("slip_relock", end_lock, 1);
            if (t == 7) check("slip_vld", end_vld, 1);
            if (t == 7) check("slip_par", end_par, 10'h354);
            if (t == 8) check("slip_period", mid_vld, 0);
            if (t == 8) check("slip_next", end_vld, 1);
        end

        // Reset five bits into a locked character
        for (int i = 0; i < 5; i++) tick(TOK[i]);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_par", parallel, 10'h0);
        check("mrst_vld", parallel_valid, 0);
        check("mrst_lock", locked, 0);
        bad = 0;
        for (int i = 5; i < 10; i++) begin
            tick(TOK[i]);
            if (parallel_valid || locked) bad++;
        end
        check("mrst_quiet", bad, 0);
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
